// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, sequencer state encoding and opcode constants.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-pc selection: jump over taken branch over sequential.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int unsigned PC_STEP = 1
) (
  input  logic [WORD_W-1:0] pc,
  input  logic [25:0]       instr_field,
  input  logic              jump,
  input  logic              branch_taken,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] pc_plus;
  logic [27:0]       jump_off;
  logic [WORD_W-1:0] branch_off;

  assign pc_plus    = pc + WORD_W'(PC_STEP);
  assign jump_off   = 28'(instr_field) * 28'(PC_STEP);
  assign branch_off = {{16{instr_field[15]}}, instr_field[15:0]} * WORD_W'(PC_STEP);

  always_comb begin
    next_pc = pc_plus;
    if (jump) begin
      next_pc = {pc_plus[31:28], jump_off};
    end else if (branch_taken) begin
      next_pc = pc_plus + branch_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle MIPS datapath with fetch handshake and halt.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned       PC_STEP     = 1,
  parameter logic [OP_W-1:0]   HALT_OPCODE = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] pc,
  output logic              pc_valid,
  input  logic              pc_ready,
  input  logic [WORD_W-1:0] instruction,
  input  logic              branch_taken,
  input  logic              jump,
  output logic              halted,
  output logic [WORD_W-1:0] retired_count
);

  state_t            state;
  logic [WORD_W-1:0] next_pc;
  logic              accept;
  logic              is_halt;

  assign accept  = pc_valid & pc_ready;
  assign is_halt = (opcode_of(instruction) == HALT_OPCODE);

  next_pc_calc #(
    .PC_STEP(PC_STEP)
  ) u_next_pc (
    .pc          (pc),
    .instr_field (instruction[25:0]),
    .jump        (jump),
    .branch_taken(branch_taken),
    .next_pc     (next_pc)
  );

  // Control inputs only matter on an accepted cycle; a stall holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (accept) begin
            retired_count <= retired_count + 32'd1;
            if (is_halt) begin
              state    <= ST_HALT;
              pc_valid <= 1'b0;
              halted   <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        ST_HALT: begin
          pc_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: three sequencers with different reset pcs, accepted fetches checked by a monitor.
module tb_pc_sequencer;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_s    [N];
  logic        valid_s [N];
  logic        ready_s [N];
  logic [31:0] instr_s [N];
  logic        br_s    [N];
  logic        jmp_s   [N];
  logic        halt_s  [N];
  logic [31:0] cnt_s   [N];

  exp_t        exp_q[$];
  logic [31:0] exp_cnt [N];
  int          vectors = 0;
  int          fails   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pc_sequencer #(
      .RESET_PC((g == 0) ? 32'h0000_0000 : (g == 1) ? 32'hFFFF_FFFF : 32'h1000_0008),
      .PC_STEP (1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc_s[g]),
      .pc_valid     (valid_s[g]),
      .pc_ready     (ready_s[g]),
      .instruction  (instr_s[g]),
      .branch_taken (br_s[g]),
      .jump         (jmp_s[g]),
      .halted       (halt_s[g]),
      .retired_count(cnt_s[g])
    );
  end

  // Monitor: every accepted fetch must match the oldest expectation.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!reset && valid_s[g] && ready_s[g]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_accept dut%0d pc=%h required none", g, pc_s[g]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.idx != 2'(g) || e.pc != pc_s[g] || e.cnt != cnt_s[g]) begin
            fails++;
            $display("FAIL accept dut%0d got pc=%h cnt=%0d, required dut%0d pc=%h cnt=%0d",
                     g, pc_s[g], cnt_s[g], e.idx, e.pc, e.cnt);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    for (int g = 0; g < N; g++) begin
      ready_s[g] = 1'b0;
      instr_s[g] = NOP;
      br_s[g]    = 1'b0;
      jmp_s[g]   = 1'b0;
    end
  endtask

  // One cycle on dut g; an accept pushes the pc it is expected to present.
  task automatic step(input int g, input logic rdy, input logic [31:0] ins,
                      input logic br, input logic jp, input logic [31:0] exp_pc);
    ready_s[g] = rdy;
    instr_s[g] = ins;
    br_s[g]    = br;
    jmp_s[g]   = jp;
    if (rdy) begin
      exp_q.push_back('{idx: 2'(g), pc: exp_pc, cnt: exp_cnt[g]});
      exp_cnt[g] = exp_cnt[g] + 32'd1;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    for (int g = 0; g < N; g++) exp_cnt[g] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    for (int g = 0; g < N; g++) exp_cnt[g] = '0;
    apply_reset();
    chk("reset_pc", pc_s[0], 32'h0);
    chk("reset_valid", 32'(valid_s[0]), 32'h0);
    chk("reset_halted", 32'(halt_s[0]), 32'h0);
    chk("reset_count", cnt_s[0], 32'h0);
    chk("reset_pc_hi", pc_s[2], 32'h1000_0008);
    @(posedge clk);
    #1;
    chk("run_valid", 32'(valid_s[0]), 32'h1);

    // Sequential fetch, then branches backward and forward
    for (int i = 0; i < 4; i++) step(0, 1'b1, NOP, 1'b0, 1'b0, 32'(i));
    chk("seq_pc", pc_s[0], 32'd4);
    chk("seq_count", cnt_s[0], 32'd4);
    step(0, 1'b1, NOP, 1'b0, 1'b0, 32'd4);
    step(0, 1'b1, 32'h1000_FFFD, 1'b1, 1'b0, 32'd5);
    step(0, 1'b1, NOP, 1'b0, 1'b0, 32'd3);
    step(0, 1'b1, NOP, 1'b0, 1'b0, 32'd4);
    step(0, 1'b1, 32'h1000_0004, 1'b1, 1'b0, 32'd5);
    step(0, 1'b1, 32'h1000_FFFC, 1'b1, 1'b0, 32'd10);

    // Stall at pc 7 with branch asserted: nothing moves
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 32'h1000_0001, 1'b1, 1'b0, 32'd0);
      chk("stall_pc", pc_s[0], 32'd7);
      chk("stall_count", cnt_s[0], 32'd10);
    end
    step(0, 1'b1, 32'h1000_0001, 1'b1, 1'b0, 32'd7);
    chk("stall_release_pc", pc_s[0], 32'd9);

    // Halt at pc 9
    step(0, 1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'd9);
    for (int i = 0; i < 10; i++) begin
      ready_s[0] = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0 || i == 9) begin
        chk("halt_flag", 32'(halt_s[0]), 32'h1);
        chk("halt_valid", 32'(valid_s[0]), 32'h0);
        chk("halt_pc", pc_s[0], 32'd9);
        chk("halt_count", cnt_s[0], 32'd12);
      end
    end
    idle_inputs();
    apply_reset();
    chk("post_halt_pc", pc_s[0], 32'h0);
    chk("post_halt_flag", 32'(halt_s[0]), 32'h0);
    chk("post_halt_count", cnt_s[0], 32'h0);
    @(posedge clk);
    #1;

    // Jump within the 0x1 region, then jump beating a taken branch
    step(2, 1'b1, 32'h0800_0040, 1'b0, 1'b1, 32'h1000_0008);
    step(2, 1'b1, 32'h0800_0080, 1'b1, 1'b1, 32'h1000_0040);
    step(2, 1'b1, NOP, 1'b0, 1'b0, 32'h1000_0080);
    chk("jump_final_pc", pc_s[2], 32'h1000_0081);

    // Wrap from all-ones, then reset in the middle of a stall
    step(1, 1'b1, NOP, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("wrap_pc", pc_s[1], 32'h0);
    step(1, 1'b1, NOP, 1'b0, 1'b0, 32'h0);
    step(1, 1'b0, 32'h1000_0005, 1'b1, 1'b0, 32'h0);
    chk("prestall_pc", pc_s[1], 32'h1);
    ready_s[1] = 1'b0;
    br_s[1]    = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    chk("midstall_reset_pc", pc_s[1], 32'hFFFF_FFFF);
    chk("midstall_reset_valid", 32'(valid_s[1]), 32'h0);
    chk("midstall_reset_count", cnt_s[1], 32'h0);
    chk("midstall_reset_halted", 32'(halt_s[1]), 32'h0);
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
